// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block as 16 words and streams the
// round words W[0..NumRounds-1] (optionally pre-added with K[t]) over a
// valid/ready handshake. Every output is a flop; w_ready_i only steers the
// next-state logic.
`timescale 1ns/1ps
module sha256_msg_schedule #(
    parameter int NumRounds = 64,
    parameter bit AddK      = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
    output logic        w_valid_o,
    output logic [31:0] w_o,
    output logic [5:0]  w_idx_o,
    output logic        w_last_o,
    input  logic        w_ready_i
);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    localparam logic [5:0] LAST_T = 6'(NumRounds - 1);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state, state_next;
    logic [31:0] win [16];
    logic [31:0] win_next [16];
    logic [3:0]  cnt, cnt_next;
    logic [5:0]  t, t_next;
    logic        load_hs, emit_hs;

    logic        ready_next, valid_next, last_next;
    logic [31:0] w_next;
    logic [5:0]  idx_next;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: sliding 16-word window; clear beats any handshake
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        t_next     = t;
        win_next   = win;
        load_hs    = (state == LOAD) && word_valid_i && word_ready_o;
        emit_hs    = (state == EMIT) && w_valid_o && w_ready_i;
        if (clear_i) begin
            state_next = LOAD;
            cnt_next   = 4'd0;
            t_next     = 6'd0;
        end else begin
            case (state)
                IDLE: state_next = LOAD;
                LOAD: begin
                    if (load_hs) begin
                        for (int i = 0; i < 15; i++) win_next[i] = win[i + 1];
                        win_next[15] = word_i;
                        cnt_next     = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state_next = EMIT;
                            t_next     = 6'd0;
                        end
                    end
                end
                EMIT: begin
                    if (emit_hs) begin
                        // win[0..15] hold W[t..t+15]; the new tail is W[t+16]
                        for (int i = 0; i < 15; i++) win_next[i] = win[i + 1];
                        win_next[15] = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
                        if (t == LAST_T) begin
                            state_next = LOAD;
                            t_next     = 6'd0;
                            cnt_next   = 4'd0;
                        end else begin
                            t_next = t + 6'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs, derived from next state
    always_comb begin
        ready_next = (state_next == LOAD);
        valid_next = (state_next == EMIT);
        idx_next   = t_next;
        last_next  = valid_next && (t_next == LAST_T);
        w_next     = win_next[0] + (AddK ? K_TAB[t_next] : 32'h0);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) win[i] <= 32'h0;
            cnt          <= 4'd0;
            t            <= 6'd0;
            word_ready_o <= 1'b0;
            w_valid_o    <= 1'b0;
            w_o          <= 32'h0;
            w_idx_o      <= 6'd0;
            w_last_o     <= 1'b0;
        end else begin
            win          <= win_next;
            cnt          <= cnt_next;
            t            <= t_next;
            word_ready_o <= ready_next;
            w_valid_o    <= valid_next;
            w_o          <= w_next;
            w_idx_o      <= idx_next;
            w_last_o     <= last_next;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: two instances (AddK=0 and AddK=1) share
// stimulus; a reference expansion fills per-instance queues at load time and
// every valid cycle is compared against the queue head.
`timescale 1ns/1ps
module tb_sha256_msg_schedule;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst, clear, word_valid, w_ready;
    logic [31:0] word;
    logic        ready0, valid0, last0, ready1, valid1, last1;
    logic [31:0] w0, w1;
    logic [5:0]  idx0, idx1;

    exp_t        q0[$];
    exp_t        q1[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] blk [16];
    logic [31:0] gw [64];
    logic [31:0] abc_ref [20];
    bit          abc_mode;
    int          valid_cycles;
    int          drain_steps;

    sha256_msg_schedule #(.NumRounds(64), .AddK(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .word_valid_i(word_valid), .word_i(word),
        .word_ready_o(ready0), .w_valid_o(valid0), .w_o(w0), .w_idx_o(idx0), .w_last_o(last0),
        .w_ready_i(w_ready)
    );

    sha256_msg_schedule #(.NumRounds(64), .AddK(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .word_valid_i(word_valid), .word_i(word),
        .word_ready_o(ready1), .w_valid_o(valid1), .w_o(w1), .w_idx_o(idx1), .w_last_o(last1),
        .w_ready_i(w_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ {10'b0, x[31:10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 16; i++) gw[i] = blk[i];
        for (int i = 16; i < 64; i++)
            gw[i] = ss1(gw[i-2]) + gw[i-7] + ss0(gw[i-15]) + gw[i-16];
        for (int i = 0; i < 64; i++) begin
            e.w = gw[i]; e.idx = 6'(i); e.last = (i == 63);
            q0.push_back(e);
            e.w = gw[i] + KT[i];
            q1.push_back(e);
        end
    endtask

    // One clock: compare any valid output to the queue head, pop on handshake.
    task automatic step();
        exp_t e;
        if (valid0) begin
            if (q0.size() == 0) begin
                chk("unexpected_valid0", 32'(valid0), 32'h0);
            end else begin
                e = q0[0];
                chk("w0", w0, e.w);
                chk("idx0", 32'(idx0), 32'(e.idx));
                chk("last0", 32'(last0), 32'(e.last));
                chk("ready_with_valid0", 32'(ready0), 32'h0);
                if (abc_mode && idx0 < 6'd20) chk("abc_word", w0, abc_ref[idx0]);
                valid_cycles++;
                if (w_ready) void'(q0.pop_front());
            end
        end
        if (valid1) begin
            if (q1.size() == 0) begin
                chk("unexpected_valid1", 32'(valid1), 32'h0);
            end else begin
                e = q1[0];
                chk("w1", w1, e.w);
                chk("idx1", 32'(idx1), 32'(e.idx));
                chk("last1", 32'(last1), 32'(e.last));
                if (w_ready) void'(q1.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input int nwords, input bit gaps);
        bit acc;
        int guard;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                word_valid = 1'b0;
                word = $urandom;
                step();
            end
            word_valid = 1'b1;
            word = blk[i];
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 50) begin
                acc = ready0;
                if (acc && i == 15) push_expected();
                step();
                guard++;
            end
            checks++;
            assert (acc) else begin
                errors++;
                $error("FAIL load_timeout observed=not_accepted expected=accepted word=%0d", i);
            end
        end
        word_valid = 1'b0;
        word = 32'h0;
        if (nwords == 16) chk("first_valid_latency", 32'(valid0), 32'h1);
    endtask

    task automatic drain(input bit random_ready, input bit junk_words);
        valid_cycles = 0;
        drain_steps = 0;
        while (q0.size() > 0 && drain_steps < 2000) begin
            w_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk_words) begin
                word_valid = 1'b1;
                word = $urandom;
            end
            step();
            drain_steps++;
        end
        word_valid = 1'b0;
        w_ready = 1'b1;
        chk("drain_left", 32'(q0.size()), 32'h0);
        chk("valid_after_block", 32'(valid0), 32'h0);
        chk("ready_after_block", 32'(ready0), 32'h1);
    endtask

    initial begin
        int guard;
        rst = 1'b1; clear = 1'b0; word_valid = 1'b0; word = 32'h0; w_ready = 1'b1;
        abc_mode = 1'b0;
        for (int i = 0; i < 20; i++) abc_ref[i] = 32'h0;
        abc_ref[0]  = 32'h61626380; abc_ref[15] = 32'h00000018;
        abc_ref[16] = 32'h61626380; abc_ref[17] = 32'h000F0000;
        abc_ref[18] = 32'h7DA86405; abc_ref[19] = 32'h600003C6;

        // Reset release
        repeat (3) step();
        chk("rst_ready", 32'(ready0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        chk("rst_w", w0, 32'h0);
        chk("rst_w_addk", w1, 32'h0);
        chk("rst_idx", 32'(idx0), 32'h0);
        chk("rst_last", 32'(last0), 32'h0);
        rst = 1'b0;
        chk("ready_release_c1", 32'(ready0), 32'h0);
        step();
        chk("ready_release_c2", 32'(ready0), 32'h1);
        chk("valid_release_c2", 32'(valid0), 32'h0);

        // "abc" block, unstalled, with junk words offered during EMIT
        for (int i = 0; i < 16; i++) blk[i] = abc_ref[i];
        abc_mode = 1'b1;
        load_block(16, 1'b0);
        chk("addk_first_word", w1, 32'hA3EC9318);
        drain(1'b0, 1'b1);
        chk("abc_valid_cycles", 32'(valid_cycles), 32'd64);
        chk("abc_drain_cycles", 32'(drain_steps), 32'd64);
        abc_mode = 1'b0;

        // Second block loads straight after the last handshake
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b0);
        drain(1'b0, 1'b0);

        // Backpressure on the "abc" block
        for (int i = 0; i < 16; i++) blk[i] = abc_ref[i];
        abc_mode = 1'b1;
        load_block(16, 1'b1);
        drain(1'b1, 1'b0);
        abc_mode = 1'b0;

        // Clear mid-EMIT at index 20 together with a handshake
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b1);
        guard = 0;
        while (!(valid0 && idx0 == 6'd20) && guard < 200) begin
            w_ready = 1'b1;
            step();
            guard++;
        end
        chk("reached_idx20", 32'(idx0), 32'd20);
        clear = 1'b1;
        w_ready = 1'b1;
        step();
        clear = 1'b0;
        q0.delete();
        q1.delete();
        chk("clear_valid", 32'(valid0), 32'h0);
        chk("clear_ready", 32'(ready0), 32'h1);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b1);
        drain(1'b1, 1'b0);

        // Reset after 7 loaded words, then a full block is required
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(7, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("midload_rst_ready", 32'(ready0), 32'h0);
        chk("midload_rst_valid", 32'(valid0), 32'h0);
        rst = 1'b0;
        step();
        chk("midload_release_ready", 32'(ready0), 32'h1);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b1);
        drain(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule stage directly upstream of the compression core.
- Accepts one 512-bit block as 16 serial 32-bit words (big-endian word order, W0 first).
- Expands the block to the round words W[0..NumRounds-1] and streams them, one word per handshake, to the round logic.
- Optionally pre-adds the round constant K[t], using the standard SHA-256 K table (K0=0x428a2f98 … K63=0xc67178f2).

Parameters:
- NumRounds, 64: number of round words emitted per block; legal range 16..64; values below 64 are for debug only.
- AddK, 0: 0 = w_o carries W[t]; 1 = w_o carries (W[t]+K[t]) mod 2^32.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous flush; aborts the current block.
- word_valid_i  in  1  input word valid.
- word_i  in  32  message word.
- word_ready_o  out  1  block accepts a word.
- w_valid_o  out  1  round word valid.
- w_o  out  32  W[t], or W[t]+K[t] when AddK=1.
- w_idx_o  out  6  round index t.
- w_last_o  out  1  high when t == NumRounds-1.
- w_ready_i  in  1  consumer accepts the round word.

Behaviour:
- Single clock domain clk_i. Reset is synchronous and active-high on rst_i.
- State machine states: IDLE, LOAD, EMIT. Reset state is IDLE.
- Reset values:
  - All outputs are registered and reset to 0: word_ready_o=0, w_valid_o=0, w_o=0, w_idx_o=0, w_last_o=0.
  - 16x32 window register win[0..15] = 0; load counter = 0; round counter t = 0.
- IDLE: moves to LOAD unconditionally on the next cycle. word_ready_o becomes 1 in the second cycle after rst_i deasserts.
- LOAD:
  - word_ready_o=1.
  - On word_valid_i && word_ready_o: shift the window down (win[i] <= win[i+1]), set win[15] <= word_i, increment the load counter.
  - On the 16th accepted word: word_ready_o=0 and state=EMIT in the next cycle. w_valid_o=1 with w_idx_o=0 in that same cycle.
  - Latency: 16th word accepted in cycle N -> first round word valid in cycle N+1.
- EMIT:
  - w_o is derived from win[0], plus K[t] when AddK=1. w_idx_o=t. w_last_o=(t==NumRounds-1).
  - Outputs hold stable while w_valid_o && !w_ready_i (no combinational path from w_ready_i to any output).
  - On handshake: shift the window down, set win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0] (all mod 2^32), increment t.
    - This yields W[t+16] uniformly for every t.
    - Values past NumRounds-1 are never emitted.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Back-to-back handshakes give one word per cycle. No bubbles within a block.
  - On the handshake with w_last_o=1: next cycle w_valid_o=0, word_ready_o=1, state=LOAD, t=0, load counter=0.
  - word_ready_o is never 1 while w_valid_o is 1. Words presented during EMIT are not consumed.
- clear_i:
  - In any state: next cycle state=LOAD, word_ready_o=1, w_valid_o=0, counters=0. Window contents are don't-care.
  - clear_i has priority over a simultaneous input or output handshake; that word is discarded and not counted.
  - Asserted during IDLE: proceeds to LOAD as normal.
- rst_i mid-operation: overrides clear_i and everything else; returns to IDLE with all reset values above.
- Width rules:
  - All additions wrap modulo 2^32; carries are discarded.
  - w_idx_o is 6 bits and never exceeds NumRounds-1.

Test Plan:
- Reset release:
  - Hold rst_i for 3 cycles, then release.
  - Required: word_ready_o=0 in the first cycle after release, 1 in the second; w_valid_o=0 throughout.
- "abc" block, AddK=0, w_ready_i=1 constant:
  - Load W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Required stream: W0..W15 echoed, then W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - Required: 64 consecutive valid cycles; w_last_o only at w_idx_o=63.
- AddK=1, same block: first output w_o=0xA3EC9318 (0x61626380+0x428a2f98).
- Backpressure:
  - Drive w_ready_i with a random pattern (~50%) on the "abc" block.
  - Required: w_o, w_idx_o and w_last_o stable while stalled; word sequence identical to the unstalled run.
- Clear mid-EMIT:
  - Assert clear_i at w_idx_o=20 together with w_ready_i=1.
  - Required: next cycle w_valid_o=0, word_ready_o=1. A fresh 16-word load then restarts at w_idx_o=0 with correct values.
- Boundary cases:
  - Assert word_valid_i during EMIT -> word not consumed.
  - Second block begins loading in the cycle after the last handshake; its outputs must match a golden model.
  - Assert rst_i during LOAD after 7 words -> IDLE, then a full 16-word load is required before any output.
